// File: rtl/servant_uart_rx.sv
// servant_uart_rx
//   8N1 UART receiver, LSB first, line idle high. The line is oversampled with
//   the system clock: start and stop bits are checked, and good bytes are
//   queued in a small first-word-fall-through FIFO behind a valid/ready
//   handshake.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx         serial line, asynchronous to i_clk
//   o_data       byte at the FIFO head (8'h00 while empty)
//   o_valid      FIFO non-empty
//   i_ready      consumer accepts o_data this cycle
//   o_busy       receiver FSM not in IDLE
//   o_frame_err  sticky: stop bit sampled low
//   o_overrun    sticky: byte dropped because the FIFO was full
//   i_clr_err    pulse that clears both sticky flags (a new error wins)
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | timing to mid start bit to confirm it is not a glitch
// DATA      | sampling 8 data bits at bit centres
// STOP      | sampling the stop bit, push the byte or flag framing
// WAIT_IDLE | after a framing error, waiting for the line to go high

module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 280,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  // Synchronizer flops reset high so leaving reset never looks like a start bit.
  logic sync1_q, sync2_q;
  logic rx_s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_req;
  logic          frame_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full;
  logic          pop, push, ovr_set;

  logic          frame_err_q, overrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pointers carry one extra wrap bit: equal means empty, only the wrap bit
  // differing means full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then; when full both pointers address the same slot and
  // the read sees the old value because the write lands at the edge.
  assign pop     = ~fifo_empty & i_ready;
  assign push    = push_req & (~fifo_full | pop);
  assign ovr_set = push_req & fifo_full & ~pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~i_clr_err);
      overrun_q   <= ovr_set   | (overrun_q   & ~i_clr_err);
    end
  end

  assign o_valid     = ~fifo_empty;
  assign o_data      = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign o_busy      = (state_q != S_IDLE);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
